// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter writing one of N_CH channel requests as {id, data} into a shared FIFO.
// Optional stall counter enabled by defining ARB_STALL_CNT_EN; default build ties STALL_CNT to 0.
module fifo_write_arbiter #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int CH_W  = $clog2(N_CH),
  localparam int FW    = WIDTH + CH_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         req_i,
  input  logic [N_CH*WIDTH-1:0]   data_in_i,
  input  logic                    fifo_full_i,
  input  logic                    cnt_clr_i,
  output logic [N_CH-1:0]         grant_o,
  output logic [FW-1:0]           fifo_din_o,
  output logic                    fifo_we_o,
  output logic [15:0]             stall_cnt_o
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   win_q;
  logic [CH_W-1:0]   win_d;
  logic [CH_W-1:0]   idx;
  logic              found;
  logic [N_CH-1:0]   grant_q;
  logic [FW-1:0]     din_q;
  logic              we_q;

  // Scan ptr, ptr+1, ... ; N_CH is a power of two so the index wraps naturally.
  always_comb begin
    win_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = ptr_q + CH_W'(i);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found && !fifo_full_i) begin
            state_q <= WRITE;
            win_q   <= win_d;
            we_q    <= 1'b1;
            grant_q <= {{(N_CH-1){1'b0}}, 1'b1} << win_d;
            din_q   <= {win_d, data_in_i[win_d*WIDTH +: WIDTH]};
          end
        end
        WRITE: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
          grant_q <= '0;
          ptr_q   <= win_q + CH_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign fifo_din_o = din_q;
  assign fifo_we_o  = we_q;

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Clear has priority over counting; count saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (cnt_clr_i) begin
      stall_q <= '0;
    end else if (state_q == IDLE && (|req_i) && fifo_full_i && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign stall_cnt_o    = '0;
`endif

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of requesting channels; legal values 2, 4, 8.
REQ-002 Parameter WIDTH, default 8, data width per channel.
REQ-003 Derived CH_W = log2(N_CH); FIFO word width FW = WIDTH + CH_W.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 REQ  input  N_CH  per-channel write request, held high until granted.
REQ-007 DATA_IN  input  N_CH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH], stable while REQ[k] high.
REQ-008 FIFO_FULL  input  1  full flag of the shared FIFO.
REQ-009 GRANT  output  N_CH  one-hot, one-cycle acknowledge; channel data accepted.
REQ-010 FIFO_DIN  output  FW  {channel id, data} toward shared FIFO data input.
REQ-011 FIFO_WE  output  1  shared FIFO write enable.
REQ-012 CNT_CLR  input  1  synchronous clear of stall counter.
REQ-013 STALL_CNT  output  16  stall counter (see Configuration).

Function
REQ-014 FSM states: IDLE, WRITE; GRANT, FIFO_WE, FIFO_DIN, PTR all registered.
REQ-015 IDLE: if |REQ and FIFO_FULL==0, select winner k, go to WRITE; otherwise stay IDLE.
REQ-016 Winner: first REQ bit set scanning PTR, PTR+1, ... mod N_CH (round-robin, PTR highest priority).
REQ-017 WRITE (exactly one cycle): FIFO_WE=1, GRANT=one-hot(k), FIFO_DIN={k[CH_W-1:0], DATA_IN slice k as sampled at IDLE->WRITE edge}; next state IDLE unconditionally.
REQ-018 On WRITE->IDLE edge PTR <= (k+1) mod N_CH; PTR unchanged in all other cycles.
REQ-019 Latency: REQ high with FIFO not full at edge t -> FIFO_WE and GRANT high for the cycle following edge t; max throughput one word per 2 cycles.
REQ-020 No arbitration in WRITE; REQ changes during WRITE ignored; requester drops REQ on the edge ending GRANT, so IDLE never re-grants a served request.
REQ-021 FIFO_FULL sampled only in IDLE; FULL asserting during WRITE does not cancel the issued write.
REQ-022 FIFO_WE, GRANT = 0 and FIFO_DIN holds last value in IDLE.
REQ-023 REQ==0 in IDLE: remain IDLE, no output change.
REQ-024 REQ deasserted before grant (protocol violation): request withdrawn, no write.

Reset
REQ-025 RESET low forces immediately, independent of CLK: state=IDLE, PTR=0, GRANT=0, FIFO_WE=0, FIFO_DIN=0, STALL_CNT=0.
REQ-026 Reset during WRITE aborts the write; GRANT not delivered; requester keeps REQ and is served after reset.
REQ-027 First arbitration occurs on the first rising edge with RESET high.

Configuration
REQ-028 Macro ARB_STALL_CNT_EN defined: STALL_CNT increments by 1 each cycle in IDLE with |REQ==1 and FIFO_FULL==1, saturates at 0xFFFF, cleared to 0 by CNT_CLR==1 (clear wins over increment).
REQ-029 Macro ARB_STALL_CNT_EN undefined: counter logic absent, STALL_CNT tied to 0, CNT_CLR ignored; ports retained.

Verification
REQ-030 N_CH=4; REQ=0001, DATA_IN ch0=0x5A, FULL=0 -> one cycle later FIFO_WE=1, GRANT=0001, FIFO_DIN=0x05A (id 0), then PTR=1.
REQ-031 REQ=1111 held, each channel dropping REQ after its grant -> grant order ch0,ch1,ch2,ch3, one write every 2 cycles, 4 words total.
REQ-032 PTR=2, REQ=0011 -> ch0 granted first, then ch1; PTR ends at 2.
REQ-033 REQ=0100, FULL=1 for 10 cycles then 0 -> no FIFO_WE during FULL, write follows first IDLE cycle with FULL=0; STALL_CNT=10 with ARB_STALL_CNT_EN, 0 without.
REQ-034 RESET low during WRITE -> FIFO_WE and GRANT drop within the same cycle, PTR=0; REQ held -> request served after reset release.
REQ-035 ARB_STALL_CNT_EN, stall held 70000 cycles -> STALL_CNT saturates at 0xFFFF; CNT_CLR pulse -> 0 on next edge.
